// File: rtl/eth_rx_pkt_buffer.sv
// Receive packet buffer: frames are written speculatively and exposed to the reader only once they end with a good FCS.
// Build option ETH_RX_BUF_STRIP_FCS_EN: a 5-byte delay line keeps the 4 FCS bytes out of the buffer.
module eth_rx_pkt_buffer #(
    parameter int AW = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_sop,
    input  logic        in_eop,
    input  logic        in_crc_ok,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] drop_count
);

`ifdef ETH_RX_BUF_STRIP_FCS_EN
    localparam int D = 5;
`else
    localparam int D = 1;
`endif
    localparam int PW = AW + 1;
    localparam int CW = $clog2(D + 1);
    localparam logic [PW-1:0] CAP = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_OVF} wr_state_e;

    wr_state_e         state_q;
    logic [PW-1:0]     wr_ptr_q, commit_ptr_q, rd_ptr_q;
    logic [D-1:0][7:0] dly_q;
    logic [CW-1:0]     dcnt_q;
    logic [15:0]       drop_q;
    logic [7:0]        out_data_q;
    logic              out_last_q, out_valid_q;

    logic [8:0]        mem [0:(1<<AW)-1];
    logic [8:0]        rd_word;
    logic              full, held, mem_we, mem_wlast, drop_evt, rd_load;

    assign full    = (wr_ptr_q - rd_ptr_q) == CAP;
    assign held    = dcnt_q == CW'(D);
    assign rd_word = mem[rd_ptr_q[AW-1:0]];

    // A RAM write happens only once the delay line is primed; the eop write carries last=1.
    always_comb begin
        mem_we    = 1'b0;
        mem_wlast = 1'b0;
        if (!in_sop && state_q == S_FILL && !full && held) begin
            if (in_eop) begin
                mem_we    = in_crc_ok;
                mem_wlast = in_crc_ok;
            end else if (in_valid) begin
                mem_we = 1'b1;
            end
        end
    end

    assign drop_evt = (in_sop && state_q == S_FILL) ||
                      (!in_sop && in_eop && ((state_q == S_FILL && !mem_we) || state_q == S_OVF));

    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr_q[AW-1:0]] <= {mem_wlast, dly_q[D-1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            dly_q        <= '0;
            dcnt_q       <= '0;
            drop_q       <= '0;
        end else begin
            if (drop_evt && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
            if (in_sop) begin
                wr_ptr_q <= commit_ptr_q;
                dcnt_q   <= '0;
                state_q  <= S_FILL;
            end else begin
                case (state_q)
                    S_FILL: begin
                        if (in_eop) begin
                            if (mem_we) begin
                                commit_ptr_q <= wr_ptr_q + PW'(1);
                                wr_ptr_q     <= wr_ptr_q + PW'(1);
                            end else begin
                                wr_ptr_q <= commit_ptr_q;
                            end
                            state_q <= S_IDLE;
                        end else if (in_valid) begin
                            for (int i = D - 1; i > 0; i--) dly_q[i] <= dly_q[i-1];
                            dly_q[0] <= in_data;
                            if (!held)     dcnt_q   <= dcnt_q + CW'(1);
                            else if (full) state_q  <= S_OVF;
                            else           wr_ptr_q <= wr_ptr_q + PW'(1);
                        end
                    end
                    S_OVF: begin
                        if (in_eop) begin
                            wr_ptr_q <= commit_ptr_q;
                            state_q  <= S_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Output register is a one-deep show-ahead stage refilled from the RAM head.
    assign rd_load = (rd_ptr_q != commit_ptr_q) && (!out_valid_q || out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q    <= '0;
            out_data_q  <= 8'h00;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (rd_load) begin
            out_data_q  <= rd_word[7:0];
            out_last_q  <= rd_word[8];
            out_valid_q <= 1'b1;
            rd_ptr_q    <= rd_ptr_q + PW'(1);
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign out_valid  = out_valid_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_eth_rx_pkt_buffer.sv
// Scoreboard bench for eth_rx_pkt_buffer: stimulus pushes expected bytes, a negedge monitor pops and compares.
module tb_eth_rx_pkt_buffer;
    localparam int AW  = 6;
    localparam int CAP = 64;
`ifdef ETH_RX_BUF_STRIP_FCS_EN
    localparam int D = 5;
`else
    localparam int D = 1;
`endif

    logic        clk, rst_n;
    logic [7:0]  in_data;
    logic        in_valid, in_sop, in_eop, in_crc_ok;
    logic [7:0]  out_data;
    logic        out_last, out_valid, out_ready;
    logic [15:0] drop_count;

    eth_rx_pkt_buffer #(.AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_sop(in_sop), .in_eop(in_eop), .in_crc_ok(in_crc_ok),
        .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
        .out_ready(out_ready), .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_d[$];
    bit         exp_l[$];
    logic [7:0] fb[$];
    int exp_drops = 0;
    int rmode = 1;

    // out_ready: 0 = held low, 1 = held high, 2 = random
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rmode == 0)      out_ready = 1'b0;
            else if (rmode == 1) out_ready = 1'b1;
            else                 out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: every transfer pops one expected byte; a stalled output must not change.
    initial begin
        bit hold_v;
        logic [7:0] hd, ed;
        bit hl, el;
        hold_v = 0; hd = 0; hl = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_v = 0;
            end else begin
                if (hold_v) begin
                    total++;
                    if (out_valid !== 1'b1 || out_data !== hd || out_last !== hl) begin
                        bad++;
                        $display("FAIL hold got v=%b d=%h l=%b exp v=1 d=%h l=%b", out_valid, out_data, out_last, hd, hl);
                    end
                end
                if (out_valid && out_ready) begin
                    total++;
                    if (exp_d.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_byte got d=%h l=%b exp none", out_data, out_last);
                    end else begin
                        ed = exp_d.pop_front();
                        el = exp_l.pop_front();
                        if (out_data !== ed || out_last !== el) begin
                            bad++;
                            $display("FAIL byte got d=%h l=%b exp d=%h l=%b", out_data, out_last, ed, el);
                        end
                    end
                end
                hold_v = out_valid && !out_ready;
                hd = out_data;
                hl = out_last;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 good, 1 bad crc, 2 abort (no eop), 3 good but expected to overflow
    task automatic send(input int len, input int kind);
        int n;
        fb.delete();
        for (int i = 0; i < len; i++) fb.push_back(8'($urandom));
        if (kind == 0) begin
            n = 0;
            while (exp_d.size() + len > CAP && n < 5000) begin
                step();
                n++;
            end
            if (n >= 5000) begin
                total++; bad++;
                $display("FAIL space_wait got pending=%0d exp <=%0d", exp_d.size(), CAP - len);
            end
        end
        step();
        in_sop = 1'b1;
        step();
        in_sop = 1'b0;
        for (int i = 0; i < len; ) begin
            if ($urandom_range(0, 7) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = fb[i];
                i++;
            end
            step();
        end
        in_valid = 1'b0;
        step();
        if (kind == 2) begin
            exp_drops++;
            return;
        end
        if (kind == 0 && len >= D) begin
            for (int i = 0; i <= len - D; i++) begin
                exp_d.push_back(fb[i]);
                exp_l.push_back(i == len - D);
            end
        end else begin
            exp_drops++;
        end
        in_eop    = 1'b1;
        in_crc_ok = (kind == 0 || kind == 3);
        step();
        in_eop    = 1'b0;
        in_crc_ok = 1'b0;
    endtask

    task automatic drain_check(input string tag);
        int n = 0;
        while (exp_d.size() != 0 && n < 20000) begin
            step();
            n++;
        end
        repeat (4) step();
        total++;
        if (exp_d.size() != 0) begin
            bad++;
            $display("FAIL %s_drain got pending=%0d exp 0", tag, exp_d.size());
        end
        total++;
        if (drop_count !== 16'(exp_drops)) begin
            bad++;
            $display("FAIL %s_drops got %0d exp %0d", tag, drop_count, exp_drops);
        end
    endtask

    task automatic chk1(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    initial begin
        int r;
        rst_n = 1'b0; in_data = 8'h00; in_valid = 1'b0; in_sop = 1'b0;
        in_eop = 1'b0; in_crc_ok = 1'b0;
        repeat (3) step();
        chk1("rst_valid", 16'(out_valid), 16'h0);
        chk1("rst_last",  16'(out_last),  16'h0);
        chk1("rst_data",  16'(out_data),  16'h0);
        chk1("rst_drops", drop_count,     16'h0);
        rst_n = 1'b1;
        step();

        // Traffic before any sop must be ignored
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            step();
        end
        in_valid = 1'b0; in_eop = 1'b1; in_crc_ok = 1'b1;
        step();
        in_eop = 1'b0; in_crc_ok = 1'b0;
        drain_check("idle");

        send(64, 0);
        drain_check("good64");
        send(64, 1);
        repeat (10) step();
        drain_check("badcrc");

        rmode = 0;
        send(100, 3);
        send(20, 0);
        repeat (5) step();
        rmode = 1;
        drain_check("overflow");

        send(30, 2);
        send(64, 0);
        drain_check("abort");

        // Reset in the middle of a stalled delivery
        rmode = 0;
        send(40, 0);
        repeat (5) step();
        chk1("pre_rst_valid", 16'(out_valid), 16'h1);
        rst_n = 1'b0;
        #1;
        chk1("mid_rst_valid", 16'(out_valid), 16'h0);
        chk1("mid_rst_drops", drop_count, 16'h0);
        exp_d.delete();
        exp_l.delete();
        exp_drops = 0;
        step();
        rst_n = 1'b1;
        rmode = 1;
        send(50, 0);
        drain_check("post_rst");

        rmode = 2;
        for (int f = 0; f < 150; f++) begin
            r = $urandom_range(0, 99);
            if (r < 78)      send($urandom_range(1, 60), 0);
            else if (r < 88) send($urandom_range(1, 60), 1);
            else if (r < 94) send($urandom_range(0, 40), 2);
            else             send($urandom_range(0, 3), 0);
        end
        send(12, 0);
        rmode = 1;
        drain_check("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
